// File: rtl/reg_status_alu.sv
// Register result-status table with attached add and multiply units.
// Results leave on one registered common data bus, which also resolves waiting table entries.
module reg_status_alu #(
  parameter int NREGS = 64,
  parameter int WORD = 32,
  parameter int TAG = 8,
  parameter logic [TAG-1:0] READY_TAG = 8'h7F,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr,
  output logic [TAG-1:0]  rd_tag,
  output logic [WORD-1:0] rd_value,
  input  logic            ren_en,
  input  logic [AW-1:0]   ren_addr,
  input  logic [TAG-1:0]  ren_tag,
  input  logic [WORD-1:0] ren_value,
  input  logic            add_valid,
  input  logic [TAG-1:0]  add_tag,
  input  logic [WORD-1:0] add_a,
  input  logic [WORD-1:0] add_b,
  output logic            add_ready,
  input  logic            mul_valid,
  input  logic [TAG-1:0]  mul_tag,
  input  logic [WORD-1:0] mul_a,
  input  logic [WORD-1:0] mul_b,
  output logic            mul_ready,
  output logic            cdb_valid,
  output logic [TAG-1:0]  cdb_tag,
  output logic [WORD-1:0] cdb_value
);

  logic [TAG-1:0]  tag_tbl_r [NREGS];
  logic [WORD-1:0] val_tbl_r [NREGS];

  logic            add_res_valid_r;
  logic [TAG-1:0]  add_res_tag_r;
  logic [WORD-1:0] add_res_value_r;

  logic            mul_s1_valid_r;
  logic [TAG-1:0]  mul_s1_tag_r;
  logic [WORD-1:0] mul_s1_a_r;
  logic [WORD-1:0] mul_s1_b_r;

  logic            mul_res_valid_r;
  logic [TAG-1:0]  mul_res_tag_r;
  logic [WORD-1:0] mul_res_value_r;

  logic            sel_mul_s;
  logic            sel_add_s;
  logic            bc_valid_s;
  logic [TAG-1:0]  bc_tag_s;
  logic [WORD-1:0] bc_value_s;
  logic            mul_adv_s;
  logic            add_accept_s;
  logic            mul_accept_s;
  logic [WORD-1:0] mul_prod_s;

  // Read port straight from table state, no bypass
  always_comb begin
    rd_tag   = tag_tbl_r[rd_addr];
    rd_value = val_tbl_r[rd_addr];
  end

  // Broadcast arbitration (multiply first) and issue handshakes
  always_comb begin
    sel_mul_s    = mul_res_valid_r;
    sel_add_s    = add_res_valid_r && !mul_res_valid_r;
    bc_valid_s   = sel_mul_s || sel_add_s;
    mul_adv_s    = !mul_res_valid_r || sel_mul_s;
    add_ready    = !add_res_valid_r || sel_add_s;
    mul_ready    = !mul_s1_valid_r || mul_adv_s;
    add_accept_s = add_valid && add_ready && (add_tag != READY_TAG);
    mul_accept_s = mul_valid && mul_ready && (mul_tag != READY_TAG);
    if (sel_mul_s) begin
      bc_tag_s   = mul_res_tag_r;
      bc_value_s = mul_res_value_r;
    end else begin
      bc_tag_s   = add_res_tag_r;
      bc_value_s = add_res_value_r;
    end
  end

  // Low half of a two's-complement product does not depend on operand signedness
  always_comb begin
    mul_prod_s = mul_s1_a_r * mul_s1_b_r;
  end

  // Add unit result holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_res_valid_r <= 1'b0;
      add_res_tag_r   <= READY_TAG;
      add_res_value_r <= '0;
    end else if (add_accept_s) begin
      add_res_valid_r <= 1'b1;
      add_res_tag_r   <= add_tag;
      add_res_value_r <= add_a + add_b;
    end else if (sel_add_s) begin
      add_res_valid_r <= 1'b0;
    end
  end

  // Multiply operand stage and result holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_s1_valid_r  <= 1'b0;
      mul_s1_tag_r    <= READY_TAG;
      mul_s1_a_r      <= '0;
      mul_s1_b_r      <= '0;
      mul_res_valid_r <= 1'b0;
      mul_res_tag_r   <= READY_TAG;
      mul_res_value_r <= '0;
    end else begin
      if (mul_adv_s) begin
        mul_res_valid_r <= mul_s1_valid_r;
        mul_res_tag_r   <= mul_s1_tag_r;
        mul_res_value_r <= mul_prod_s;
      end
      if (mul_accept_s) begin
        mul_s1_valid_r <= 1'b1;
        mul_s1_tag_r   <= mul_tag;
        mul_s1_a_r     <= mul_a;
        mul_s1_b_r     <= mul_b;
      end else if (mul_adv_s) begin
        mul_s1_valid_r <= 1'b0;
      end
    end
  end

  // Common data bus registers; tag and value hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= READY_TAG;
      cdb_value <= '0;
    end else if (bc_valid_s) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= bc_tag_s;
      cdb_value <= bc_value_s;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  // Table update: a rename names the newer producer, so it overrides a same-edge broadcast
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        tag_tbl_r[i] <= READY_TAG;
        val_tbl_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (ren_en && (ren_addr == AW'(i))) begin
          tag_tbl_r[i] <= ren_tag;
          if (ren_tag == READY_TAG) begin
            val_tbl_r[i] <= ren_value;
          end else begin
            val_tbl_r[i] <= val_tbl_r[i];
          end
        end else if (bc_valid_s && (bc_tag_s != READY_TAG) && (tag_tbl_r[i] == bc_tag_s)) begin
          tag_tbl_r[i] <= READY_TAG;
          val_tbl_r[i] <= bc_value_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_status_alu.sv
// Scoreboard bench for reg_status_alu: directed issues push expected broadcasts,
// a negedge monitor pops and compares every CDB broadcast.
module tb_reg_status_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_tag;
  logic [31:0] rd_value;
  logic        ren_en;
  logic [5:0]  ren_addr;
  logic [7:0]  ren_tag;
  logic [31:0] ren_value;
  logic        add_valid;
  logic [7:0]  add_tag;
  logic [31:0] add_a, add_b;
  logic        add_ready;
  logic        mul_valid;
  logic [7:0]  mul_tag;
  logic [31:0] mul_a, mul_b;
  logic        mul_ready;
  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_value;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  reg_status_alu dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_value(rd_value),
    .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag), .ren_value(ren_value),
    .add_valid(add_valid), .add_tag(add_tag), .add_a(add_a), .add_b(add_b), .add_ready(add_ready),
    .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [5:0] a, input logic [7:0] t, input logic [31:0] v);
    rd_addr = a;
    #1;
    chk({name, "_tag"}, {24'h0, rd_tag}, {24'h0, t});
    chk({name, "_val"}, rd_value, v);
  endtask

  task automatic do_ren(input logic [5:0] a, input logic [7:0] t, input logic [31:0] v);
    ren_en = 1'b1; ren_addr = a; ren_tag = t; ren_value = v;
    tick();
    ren_en = 1'b0;
  endtask

  // Monitor: every cycle with cdb_valid high is one broadcast
  always @(negedge clk) begin
    if (rst_n && cdb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL cdb_unexpected actual=%h_%h expected=none", cdb_tag, cdb_value);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({cdb_tag, cdb_value} !== e) begin
          failures++;
          $display("FAIL cdb_bcast actual=%h_%h expected=%h_%h", cdb_tag, cdb_value, e[39:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rd_addr = 6'd0;
    ren_en = 1'b0; ren_addr = 6'd0; ren_tag = 8'h00; ren_value = 32'h0;
    add_valid = 1'b0; add_tag = 8'h00; add_a = 32'h0; add_b = 32'h0;
    mul_valid = 1'b0; mul_tag = 8'h00; mul_a = 32'h0; mul_b = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    read_chk("rst_r0", 6'd0, 8'h7F, 32'h0);
    read_chk("rst_r63", 6'd63, 8'h7F, 32'h0);
    chk("rst_add_ready", {31'h0, add_ready}, 32'h1);
    chk("rst_mul_ready", {31'h0, mul_ready}, 32'h1);
    chk("rst_cdb_valid", {31'h0, cdb_valid}, 32'h0);
    chk("rst_cdb_tag", {24'h0, cdb_tag}, 32'h7F);

    // Add resolves a renamed register
    do_ren(6'd5, 8'h20, 32'h0);
    read_chk("r5_pending", 6'd5, 8'h20, 32'h0);
    add_valid = 1'b1; add_tag = 8'h20; add_a = 32'd7; add_b = -32'sd3;
    exp_q.push_back({8'h20, 32'd4});
    tick();
    add_valid = 1'b0;
    tick();
    read_chk("r5_done", 6'd5, 8'h7F, 32'd4);

    // Signed multiply resolves two registers with the same tag
    do_ren(6'd1, 8'h40, 32'h0);
    do_ren(6'd2, 8'h40, 32'h0);
    mul_valid = 1'b1; mul_tag = 8'h40; mul_a = -32'sd6; mul_b = 32'h10000001;
    exp_q.push_back({8'h40, 32'h9FFFFFFA});
    tick();
    mul_valid = 1'b0;
    tick();
    read_chk("r1_pending", 6'd1, 8'h40, 32'h0);
    tick();
    read_chk("r1_done", 6'd1, 8'h7F, 32'h9FFFFFFA);
    read_chk("r2_done", 6'd2, 8'h7F, 32'h9FFFFFFA);

    // Contention: mul wins, add stalls, dropped retry accepted once later
    mul_valid = 1'b1; mul_tag = 8'h41; mul_a = 32'd3; mul_b = 32'd5;
    exp_q.push_back({8'h41, 32'd15});
    tick();
    mul_valid = 1'b0;
    add_valid = 1'b1; add_tag = 8'h42; add_a = 32'd10; add_b = 32'd20;
    exp_q.push_back({8'h42, 32'd30});
    tick();
    chk("stall_add_ready", {31'h0, add_ready}, 32'h0);
    add_tag = 8'h43; add_a = 32'd1; add_b = 32'd1;
    tick();
    chk("retry_add_ready", {31'h0, add_ready}, 32'h1);
    exp_q.push_back({8'h43, 32'd2});
    tick();
    add_valid = 1'b0;
    tick(); tick();

    // Same-edge broadcast and rename of r9: rename wins, value kept
    do_ren(6'd9, 8'h7F, 32'h12345678);
    do_ren(6'd9, 8'h21, 32'h0);
    do_ren(6'd10, 8'h21, 32'h0);
    add_valid = 1'b1; add_tag = 8'h21; add_a = 32'd1; add_b = 32'd2;
    exp_q.push_back({8'h21, 32'd3});
    tick();
    add_valid = 1'b0;
    do_ren(6'd9, 8'h22, 32'h0);
    read_chk("r9_renamed", 6'd9, 8'h22, 32'h12345678);
    read_chk("r10_resolved", 6'd10, 8'h7F, 32'd3);

    // Immediate move, add wraparound, READY_TAG issue dropped
    do_ren(6'd3, 8'h7F, 32'hDEADBEEF);
    read_chk("r3_move", 6'd3, 8'h7F, 32'hDEADBEEF);
    add_valid = 1'b1; add_tag = 8'h23; add_a = 32'h7FFFFFFF; add_b = 32'h1;
    exp_q.push_back({8'h23, 32'h80000000});
    tick();
    add_tag = 8'h7F; add_a = 32'd5; add_b = 32'd5;
    tick();
    add_valid = 1'b0;
    tick(); tick();

    // Reset mid-multiply discards the in-flight result
    mul_valid = 1'b1; mul_tag = 8'h50; mul_a = 32'd2; mul_b = 32'd2;
    tick();
    mul_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_cdb_valid", {31'h0, cdb_valid}, 32'h0);
    chk("midrst_mul_ready", {31'h0, mul_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_bcast", {31'h0, cdb_valid}, 32'h0);
    end
    read_chk("post_rst_r3", 6'd3, 8'h7F, 32'h0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_status_alu.md
# reg_status_alu

Register-result-status table with attached integer add and multiply units, serving as the rename/writeback core of the reservation-station datapath. It tracks, for each architectural register, either a committed 32-bit value or the tag of the unit that will produce it. Results from the add and multiply units are broadcast on a single registered common data bus (CDB), which also updates every waiting register entry.

## Interface
Parameters:
- NREGS, 64, number of architectural registers
- WORD, 32, data width
- TAG, 8, unit tag width
- READY_TAG, 8'h7F, tag meaning "register holds its value"

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  6  read-port register index
- rd_tag  out  8  tag of rd_addr
- rd_value  out  32  value of rd_addr
- ren_en  in  1  rename/write strobe
- ren_addr  in  6  target register
- ren_tag  in  8  new producer tag
- ren_value  in  32  value; used only when ren_tag==READY_TAG
- add_valid  in  1  issue add
- add_tag  in  8  destination tag of the add
- add_a  in  32  signed operand
- add_b  in  32  signed operand
- add_ready  out  1  add unit can accept this cycle
- mul_valid  in  1  issue multiply
- mul_tag  in  8  destination tag of the multiply
- mul_a  in  32  signed operand
- mul_b  in  32  signed operand
- mul_ready  out  1  multiply unit can accept this cycle
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  8  broadcast tag
- cdb_value  out  32  broadcast value

## Operation
- Table: NREGS entries of {tag, value}.
- Read port: combinational from current table state only; there is no CDB or rename bypass.
- Rename (ren_en=1):
  - If ren_tag != READY_TAG, the entry's tag is set to ren_tag and its value is unchanged.
  - If ren_tag == READY_TAG, both tag and value are written (immediate move).
- CDB update: while cdb_valid is being set for tag T, every entry with tag==T, T!=READY_TAG, gets value=cdb_value and tag=READY_TAG. This happens on the same edge that loads the cdb_* registers.
- Same edge, same register, rename and CDB: rename wins, because it names the newer producer.
- ADD: a+b, wrapping, low 32 bits.
- MUL: a*b signed, low 32 bits of the 64-bit product.
- Add unit: one result holding register (add_res).
- Mul unit: stage register (mul_s1, holds operands and tag) followed by holding register (mul_res).
- Arbitration: one broadcast per cycle, mul_res priority over add_res. The losing result stays held.
- add_ready = !add_res.valid || add_res selected this cycle.
- mul_ready = !mul_s1.valid || mul_s1 advances this cycle. mul_s1 advances when !mul_res.valid or mul_res is selected.
- Issue with valid=1 and ready=0 is ignored; the source must hold and retry.
- Issue with tag==READY_TAG is dropped; units never broadcast READY_TAG.
- If no result is held, cdb_valid=0 next cycle; cdb_tag/cdb_value hold their previous values.

## Timing
- Reset, asynchronous, all state:
  - table tag=READY_TAG, value=0
  - add_res, mul_s1, mul_res invalid
  - cdb_valid=0, cdb_tag=READY_TAG, cdb_value=0
  - add_ready=1, mul_ready=1
- Reset mid-operation discards all in-flight results.
- Add latency: issue sampled at edge 0, result in add_res. Edge 1 broadcasts it (cdb_valid high in cycle 1) and updates the table.
- Mul latency: edge 0 to mul_s1, edge 1 to mul_res, edge 2 broadcasts.
- Both results ready on the same edge: mul broadcast first, add one cycle later. add_ready=0 during that stall cycle.
- Throughput: one add and one mul issue per cycle when uncontended. Combined broadcast is limited to 1 per cycle.

## Test plan
- Reset, then read regs 0 and 63 -> rd_tag=8'h7F, rd_value=0.
- Rename r5 to tag 8'h20; add tag 8'h20, a=7, b=-3 -> cdb {1, 8'h20, 4} two cycles after issue; r5 then reads {7F, 4}.
- Rename r1 and r2 to tag 8'h40; mul tag 8'h40, a=-6, b=0x10000001 -> low-32 product broadcast at cycle 3; both r1 and r2 resolve.
- Add and mul complete on the same edge -> mul broadcast first, add the next cycle; add_ready=0 for one cycle; a dropped retry is not double-issued.
- Same edge: CDB tag 8'h21 resolving r9 and rename r9 to 8'h22 -> r9 tag=8'h22, value unchanged.
- Rename r3 with ren_tag=7F, ren_value=0xDEADBEEF -> reads {7F, DEADBEEF}. Add a=0x7FFFFFFF, b=1 -> 0x80000000. Assert rst_n mid-mul -> no broadcast follows.
